y86_byte_mem: RTL and testbench

Y86_BYTE_MEM -- requirements
Module: y86_byte_mem

---
 rtl/y86_byte_mem.sv | 188 ++++++++++++++++++
 tb/tb_y86_byte_mem.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_byte_mem.sv
// Byte-addressed y86 data memory with a posted-write buffer, a 4-cycle drain and a
// power-on clear sequence that holds the core in reset until the array is zeroed.
module y86_byte_mem #(
  parameter int ADDR_W   = 10,
  parameter int WB_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     bus_A,
  input  logic                            bus_RE,
  input  logic                            bus_WE,
  input  logic [31:0]                     bus_wdata,
  output logic [31:0]                     bus_rdata,
  output logic                            cpu_rst,
  output logic                            init_busy,
  input  logic                            ld_valid,
  input  logic [ADDR_W-1:0]               ld_addr,
  input  logic [7:0]                      ld_data,
  output logic                            ld_ready,
  output logic [$clog2(WB_DEPTH+1)-1:0]   wb_count,
  output logic                            err_oor,
  output logic                            err_ovf
);

  localparam int MEM_SIZE = 1 << ADDR_W;
  localparam int CNT_W    = $clog2(WB_DEPTH + 1);
  localparam int PTR_W    = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

  typedef enum logic {C_CLEAR, C_READY} clr_state_t;
  typedef enum logic [2:0] {D_IDLE, D_B0, D_B1, D_B2, D_B3} drain_state_t;

  logic [7:0]        mem [MEM_SIZE];
  logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
  logic [31:0]       wb_data [WB_DEPTH];

  clr_state_t        clr_q, clr_d;
  logic [ADDR_W-1:0] clr_addr_q;
  drain_state_t      drn_q, drn_d;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_oor_q, err_ovf_q;

  logic [ADDR_W-1:0] a_lo;
  logic              in_range, push, full, pop, accept, ovf;
  logic              drain_we;
  logic [1:0]        drain_off;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wbyte;

  logic [31:0]       fwd_rdata;
  logic [ADDR_W-1:0] rd_byte_addr, rd_offs;
  logic [7:0]        rd_byte;
  logic [PTR_W-1:0]  rd_slot;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(WB_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign a_lo      = bus_A[ADDR_W-1:0];
  assign in_range  = (bus_A >> ADDR_W) == 32'd0;
  // rst is folded in so nothing is accepted or read while the reset edge is pending.
  assign init_busy = rst | (clr_q == C_CLEAR);
  assign cpu_rst   = rst | init_busy;
  assign push      = bus_WE & in_range & ~init_busy;
  assign full      = cnt_q == CNT_W'(WB_DEPTH);
  assign pop       = drn_q == D_B3;
  assign accept    = push & (~full | pop);
  assign ovf       = push & full & ~pop;
  assign cnt_d     = cnt_q + CNT_W'(accept) - CNT_W'(pop);
  assign ld_ready  = ~init_busy & (cnt_q == '0) & (drn_q == D_IDLE);
  assign wb_count  = cnt_q;
  assign err_oor   = err_oor_q;
  assign err_ovf   = err_ovf_q;

  // Clear sequencer
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      clr_q      <= C_CLEAR;
      clr_addr_q <= '0;
    end else begin
      clr_q <= clr_d;
      if (clr_q == C_CLEAR) clr_addr_q <= clr_addr_q + 1'b1;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves clr_d unassigned (no latch).
    clr_d = clr_q;
    if (clr_q == C_CLEAR && clr_addr_q == {ADDR_W{1'b1}}) clr_d = C_READY;
  end

  // Drain sequencer: one byte of the head entry per cycle, pop after the fourth
  always_ff @(posedge clk) begin
    if (rst) begin
      drn_q     <= D_IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      err_oor_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      drn_q     <= drn_d;
      cnt_q     <= cnt_d;
      if (accept) tail_q <= ptr_inc(tail_q);
      if (pop)    head_q <= ptr_inc(head_q);
      err_oor_q <= err_oor_q | ((bus_RE | bus_WE) & ~in_range);
      err_ovf_q <= err_ovf_q | ovf;
    end
  end

  always_comb begin
    drn_d     = drn_q;
    drain_we  = 1'b1;
    drain_off = 2'd0;
    unique case (drn_q)
      D_IDLE: begin
        drain_we = 1'b0;
        if (cnt_q != '0) drn_d = D_B0;
      end
      D_B0: begin drain_off = 2'd0; drn_d = D_B1; end
      D_B1: begin drain_off = 2'd1; drn_d = D_B2; end
      D_B2: begin drain_off = 2'd2; drn_d = D_B3; end
      D_B3: begin
        drain_off = 2'd3;
        drn_d     = (cnt_d != '0) ? D_B0 : D_IDLE;
      end
      default: begin drain_we = 1'b0; drn_d = D_IDLE; end
    endcase
  end

  // Entry payloads carry no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (accept) begin
      wb_addr[tail_q] <= a_lo;
      wb_data[tail_q] <= bus_wdata;
    end
  end

  // Single byte-wide array port: clear, then drain, then preload
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wbyte = '0;
    if (clr_q == C_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
    end else if (drain_we) begin
      mem_we    = 1'b1;
      mem_waddr = wb_addr[head_q] + ADDR_W'(drain_off);
      mem_wbyte = wb_data[head_q][{drain_off, 3'b000} +: 8];
    end else if (ld_valid && ld_ready) begin
      mem_we    = 1'b1;
      mem_waddr = ld_addr;
      mem_wbyte = ld_data;
    end
  end

  // NOTE: the array is deliberately not reset; the clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wbyte;
  end

  // Read path: each byte comes from the newest buffered entry covering it, else the array
  always_comb begin
    fwd_rdata    = '0;
    rd_byte_addr = '0;
    rd_offs      = '0;
    rd_byte      = '0;
    rd_slot      = '0;
    for (int k = 0; k < 4; k++) begin
      rd_byte_addr = a_lo + ADDR_W'(k);
      rd_byte      = mem[rd_byte_addr];
      for (int i = 0; i < WB_DEPTH; i++) begin
        rd_slot = PTR_W'((int'(head_q) + i) % WB_DEPTH);
        rd_offs = rd_byte_addr - wb_addr[rd_slot];
        if (i < int'(cnt_q) && rd_offs[ADDR_W-1:2] == '0)
          rd_byte = wb_data[rd_slot][{rd_offs[1:0], 3'b000} +: 8];
      end
      fwd_rdata[8*k +: 8] = rd_byte;
    end
  end

  assign bus_rdata = (bus_RE && !init_busy && in_range) ? fwd_rdata : 32'd0;

endmodule

// File: tb/tb_y86_byte_mem.sv
// Self-checking bench for y86_byte_mem: directed scenarios plus randomized traffic
// compared against a flat byte-array model of the memory.
module tb_y86_byte_mem;
  localparam int ADDR_W   = 10;
  localparam int WB_DEPTH = 2;
  localparam int MEM_SIZE = 1 << ADDR_W;

  logic        clk, rst;
  logic [31:0] bus_A, bus_wdata, bus_rdata;
  logic        bus_RE, bus_WE;
  logic        cpu_rst, init_busy;
  logic        ld_valid, ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]  ld_data;
  logic [$clog2(WB_DEPTH+1)-1:0] wb_count;
  logic        err_oor, err_ovf;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] ref_mem [MEM_SIZE];

  y86_byte_mem #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus_A(bus_A), .bus_RE(bus_RE), .bus_WE(bus_WE),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .cpu_rst(cpu_rst),
    .init_busy(init_busy), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_ready(ld_ready), .wb_count(wb_count),
    .err_oor(err_oor), .err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Architectural view: a word read is four little-endian bytes, wrapping at the top.
  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a >= MEM_SIZE) return r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_mem[(int'(a[ADDR_W-1:0]) + k) % MEM_SIZE];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) ref_mem[(int'(a[ADDR_W-1:0]) + k) % MEM_SIZE] = d[8*k +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 8'h00;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'($urandom_range(0, MEM_SIZE - 1));
    return (32'h3FA + 32'($urandom_range(0, 11))) & 32'h3FF;
  endfunction

  task automatic idle_inputs();
    bus_A = '0; bus_RE = 1'b0; bus_WE = 1'b0; bus_wdata = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  // Runs cycles until the clear sequence ends; returns how many negedges saw init_busy high.
  task automatic wait_clear(output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (wb_count !== '0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s: write buffer still holds %0d entries after %0d cycles", name, wb_count, budget);
    end
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (cpu_rst !== 1'b1 || ld_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: cpu_rst=%b ld_ready=%b, want 1/0", cpu_rst, ld_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_RE = 1'b1; bus_A = 32'h0;
    #1;
    vectors++;
    if (wb_count !== '0 || err_oor !== 1'b0 || err_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: wb_count=%0d err_oor=%b err_ovf=%b, want 0/0/0", wb_count, err_oor, err_ovf);
    end
    vectors++;
    if (init_busy !== 1'b1 || cpu_rst !== 1'b1 || ld_ready !== 1'b0 || bus_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL clear_start: init_busy=%b cpu_rst=%b ld_ready=%b rdata=%h, want 1/1/0/0",
               init_busy, cpu_rst, ld_ready, bus_rdata);
    end
    wait_clear(n);
    vectors++;
    if (n !== MEM_SIZE) begin
      miscompares++;
      $display("FAIL clear_length: init_busy high for %0d cycles, want %0d", n, MEM_SIZE);
    end
    vectors++;
    if (cpu_rst !== 1'b0 || ld_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_end: cpu_rst=%b ld_ready=%b, want 0/1", cpu_rst, ld_ready);
    end
    model_clear();
    for (int a = 0; a < MEM_SIZE; a += 4) begin
      @(negedge clk);
      bus_RE = 1'b1; bus_A = 32'(a);
      #1;
      vectors++;
      if (bus_rdata !== model_read(bus_A)) begin
        miscompares++;
        $display("FAIL cleared_read A=%h: got %h want %h", bus_A, bus_rdata, model_read(bus_A));
      end
    end
    idle_inputs();
  endtask

  task automatic test_preload();
    logic [7:0] prog [4];
    logic [31:0] a;
    prog[0] = 8'h30; prog[1] = 8'hF2; prog[2] = 8'h05; prog[3] = 8'h00;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i < 4) begin
        ld_addr = ADDR_W'(i); ld_data = prog[i];
      end else begin
        a = rand_addr();
        ld_addr = a[ADDR_W-1:0]; ld_data = 8'($urandom);
        if (ld_addr < 4) ld_addr = ADDR_W'(4);
      end
      ld_valid = 1'b1;
      #1;
      vectors++;
      if (ld_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL preload_ready byte %0d: ld_ready=%b want 1", i, ld_ready);
      end
      ref_mem[ld_addr] = ld_data;
    end
    @(negedge clk);
    idle_inputs();
    bus_RE = 1'b1; bus_A = 32'h0;
    #1;
    vectors++;
    if (bus_rdata !== 32'h0005F230) begin
      miscompares++;
      $display("FAIL preload_read: got %h want 0005f230", bus_rdata);
    end
    idle_inputs();
  endtask

  task automatic test_wrap_forward();
    logic [31:0] exp;
    @(negedge clk);
    bus_WE = 1'b1; bus_RE = 1'b1; bus_A = 32'h3FE; bus_wdata = 32'hDEADBEEF;
    #1;
    exp = model_read(32'h3FE);
    vectors++;
    if (bus_rdata !== exp) begin
      miscompares++;
      $display("FAIL same_cycle_read: got %h want pre-write %h", bus_rdata, exp);
    end
    model_write(32'h3FE, 32'hDEADBEEF);
    @(negedge clk);
    bus_WE = 1'b0;
    #1;
    vectors++;
    if (bus_rdata !== 32'hDEADBEEF || wb_count !== 1) begin
      miscompares++;
      $display("FAIL forward_wrap: rdata=%h wb_count=%0d, want deadbeef/1", bus_rdata, wb_count);
    end
    wait_drain("wrap_drain", 20);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_RE = 1'b1; bus_A = (32'h3FE + 32'(i)) & 32'h3FF;
      #1;
      vectors++;
      if (bus_rdata !== model_read(bus_A)) begin
        miscompares++;
        $display("FAIL wrap_array A=%h: got %h want %h", bus_A, bus_rdata, model_read(bus_A));
      end
      if (i == 2) begin
        vectors++;
        if (bus_rdata[15:0] !== 16'hDEAD) begin
          miscompares++;
          $display("FAIL wrap_low_bytes: got %h want dead", bus_rdata[15:0]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_overflow();
    int peak;
    logic [31:0] d;
    peak = 0;
    vectors++;
    if (err_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_initial: err_ovf=%b want 0", err_ovf);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d = $urandom;
      bus_WE = 1'b1; bus_RE = 1'b0; bus_A = 32'h080 + 32'(16 * i); bus_wdata = d;
      #1;
      if (int'(wb_count) > peak) peak = int'(wb_count);
      if (i < 2) model_write(bus_A, d);
    end
    @(negedge clk);
    bus_WE = 1'b0;
    #1;
    if (int'(wb_count) > peak) peak = int'(wb_count);
    vectors++;
    if (err_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_flag: err_ovf=%b want 1", err_ovf);
    end
    for (int n = 0; n < 20 && wb_count !== '0; n++) begin
      @(negedge clk); #1;
      if (int'(wb_count) > peak) peak = int'(wb_count);
    end
    vectors++;
    if (peak !== 2) begin
      miscompares++;
      $display("FAIL ovf_peak: wb_count peaked at %0d want 2", peak);
    end
    wait_drain("ovf_drain", 20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_RE = 1'b1; bus_A = 32'h080 + 32'(16 * i);
      #1;
      vectors++;
      if (bus_rdata !== model_read(bus_A)) begin
        miscompares++;
        $display("FAIL ovf_contents A=%h: got %h want %h", bus_A, bus_rdata, model_read(bus_A));
      end
    end
    idle_inputs();
  endtask

  task automatic test_oor();
    @(negedge clk);
    bus_RE = 1'b1; bus_A = 32'h0000_0400;
    #1;
    vectors++;
    if (bus_rdata !== 32'h0 || err_oor !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_read: rdata=%h err_oor=%b, want 0/0 before the edge", bus_rdata, err_oor);
    end
    @(negedge clk);
    bus_RE = 1'b0; bus_WE = 1'b1; bus_wdata = $urandom;
    #1;
    vectors++;
    if (err_oor !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_flag: err_oor=%b want 1", err_oor);
    end
    @(negedge clk);
    bus_WE = 1'b0; bus_RE = 1'b1; bus_A = 32'hFFFF_FFFC;
    #1;
    vectors++;
    if (wb_count !== '0 || bus_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL oor_write_dropped: wb_count=%0d rdata=%h, want 0/0", wb_count, bus_rdata);
    end
    vectors++;
    if (err_oor !== 1'b1 || err_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL sticky_flags: err_oor=%b err_ovf=%b, want 1/1", err_oor, err_ovf);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus_A = 32'(4 * i);
      #1;
      vectors++;
      if (bus_rdata !== model_read(bus_A)) begin
        miscompares++;
        $display("FAIL oor_no_change A=%h: got %h want %h", bus_A, bus_rdata, model_read(bus_A));
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int len;
    bit done;
    logic [31:0] a, d;
    for (int b = 0; b < 150; b++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        idle_inputs();
        a = rand_addr();
        ld_valid = 1'b1; ld_addr = a[ADDR_W-1:0]; ld_data = 8'($urandom);
        #1;
        vectors++;
        if (ld_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL rand_ld_ready: ld_ready=%b want 1 with empty buffer", ld_ready);
        end
        ref_mem[ld_addr] = ld_data;
      end
      len = $urandom_range(1, 2);
      for (int j = 0; j < len; j++) begin
        @(negedge clk);
        a = rand_addr();
        d = $urandom;
        bus_WE = 1'b1; bus_A = a; bus_wdata = d; bus_RE = 1'($urandom_range(0, 1));
        ld_valid = (j > 0); ld_addr = ADDR_W'($urandom); ld_data = 8'($urandom);
        #1;
        if (bus_RE) begin
          vectors++;
          if (bus_rdata !== model_read(a)) begin
            miscompares++;
            $display("FAIL rand_wr_read A=%h: got %h want %h", a, bus_rdata, model_read(a));
          end
        end
        if (j > 0) begin
          vectors++;
          if (ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_ld_blocked: ld_ready=%b want 0 while buffer busy", ld_ready);
          end
        end
        model_write(a, d);
      end
      done = 1'b0;
      for (int n = 0; n < 30 && !done; n++) begin
        @(negedge clk);
        idle_inputs();
        bus_A = rand_addr(); bus_RE = 1'($urandom_range(0, 1));
        #1;
        if (bus_RE) begin
          vectors++;
          if (bus_rdata !== model_read(bus_A)) begin
            miscompares++;
            $display("FAIL rand_read A=%h: got %h want %h", bus_A, bus_rdata, model_read(bus_A));
          end
        end
        if (wb_count === '0) done = 1'b1;
      end
      vectors++;
      if (!done) begin
        miscompares++;
        $display("FAIL rand_drain: buffer not empty after 30 cycles (wb_count=%0d)", wb_count);
      end
    end
    idle_inputs();
  endtask

  task automatic test_rst_mid_drain();
    int n;
    @(negedge clk);
    bus_WE = 1'b1; bus_A = 32'h100; bus_wdata = 32'hA5A5_A5A5;
    #1;
    repeat (4) begin
      @(negedge clk);
      idle_inputs();
    end
    #1;
    vectors++;
    if (wb_count !== 1) begin
      miscompares++;
      $display("FAIL mid_drain_pending: wb_count=%0d want 1", wb_count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (wb_count !== '0 || init_busy !== 1'b1 || cpu_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_drain_rst: wb_count=%0d init_busy=%b cpu_rst=%b, want 0/1/1", wb_count, init_busy, cpu_rst);
    end
    vectors++;
    if (err_oor !== 1'b0 || err_ovf !== 1'b0 || ld_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_drain_flags: err_oor=%b err_ovf=%b ld_ready=%b, want 0/0/0", err_oor, err_ovf, ld_ready);
    end
    wait_clear(n);
    vectors++;
    if (n !== MEM_SIZE) begin
      miscompares++;
      $display("FAIL reclear_length: init_busy high for %0d cycles, want %0d", n, MEM_SIZE);
    end
    model_clear();
    for (int i = -1; i < 2; i++) begin
      @(negedge clk);
      bus_RE = 1'b1; bus_A = 32'h100 + 32'(4 * i);
      #1;
      vectors++;
      if (bus_rdata !== 32'h0 || bus_rdata !== model_read(bus_A)) begin
        miscompares++;
        $display("FAIL reclear_read A=%h: got %h want 00000000", bus_A, bus_rdata);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_preload();
    test_wrap_forward();
    test_overflow();
    test_oor();
    test_random();
    test_rst_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
